// File: rtl/frame_scheduler_pkg.sv
// rtl/frame_scheduler_pkg.sv - shared state codes, default parameters and sizing helpers
package frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SKIP      = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_ARM       = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAIL      = 3'd7
    } sched_state_t;

    localparam int DEF_SKIP_FRAMES  = 2;
    localparam int DEF_FLUSH_CYCLES = 16;
    localparam int DEF_CFG_TIMEOUT  = 12500000;
    localparam int DEF_CFG_RETRIES  = 3;
    localparam int DEF_SOF_TIMEOUT  = 12500000;

    // Bits needed to hold the value max_val itself, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - loadable saturating down-counter with terminal-count flag
module sched_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Flags the last cycle of a loaded interval; a zero load expires at once.
    assign tc = (count <= WIDTH'(1));

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - camera config, frame skip, pipeline flush and stream gating sequencer
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int SKIP_FRAMES  = DEF_SKIP_FRAMES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CFG_TIMEOUT  = DEF_CFG_TIMEOUT,
    parameter int CFG_RETRIES  = DEF_CFG_RETRIES,
    parameter int SOF_TIMEOUT  = DEF_SOF_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sof,
    input  logic       i_cfg_done,
    input  logic       i_sw_gaussian,
    output logic       o_cfg_start,
    output logic       o_gaussian_enable,
    output logic       o_pipe_flush,
    output logic       o_stream_en,
    output logic [2:0] o_state,
    output logic       o_cfg_fail
);

    localparam int TMR_W = cnt_width(max3(CFG_TIMEOUT, FLUSH_CYCLES, SOF_TIMEOUT));
    localparam int ATT_W = cnt_width(CFG_RETRIES);
    localparam int SOF_W = cnt_width(SKIP_FRAMES);
    localparam logic [ATT_W-1:0] ATT_MAX = '1;
    localparam logic [SOF_W-1:0] SOF_MAX = '1;

    sched_state_t     state;
    sched_state_t     next_state;
    logic [ATT_W-1:0] attempt_cnt;
    logic [SOF_W-1:0] sof_cnt;
    logic             pending;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_tc;

    // Config wait, flush and sof watchdog never overlap, so one timer serves all three.
    sched_timer #(.WIDTH(TMR_W)) u_timer (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_CFG;
            ST_CFG:  next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_cfg_done) begin
                    next_state = (SKIP_FRAMES == 0) ? ST_FLUSH : ST_SKIP;
                end else if (tmr_tc) begin
                    next_state = (attempt_cnt < ATT_W'(CFG_RETRIES)) ? ST_CFG : ST_FAIL;
                end
            end
            ST_SKIP: begin
                if (SKIP_FRAMES == 0) begin
                    next_state = ST_FLUSH;
                end else if (i_sof && (int'(sof_cnt) + 1 >= SKIP_FRAMES)) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: if (tmr_tc) next_state = ST_ARM;
            ST_ARM:   if (i_sof) next_state = ST_RUN;
            ST_RUN: begin
                if (i_sof) begin
                    if (pending) next_state = ST_FLUSH;
                end else if (tmr_tc) begin
                    next_state = ST_CFG;
                end
            end
            ST_FAIL: next_state = ST_FAIL;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load = (next_state != state) || ((state == ST_RUN) && i_sof);
        case (next_state)
            ST_WAIT_DONE: tmr_val = TMR_W'(CFG_TIMEOUT);
            ST_FLUSH:     tmr_val = TMR_W'(FLUSH_CYCLES);
            ST_RUN:       tmr_val = TMR_W'(SOF_TIMEOUT);
            default:      tmr_val = '0;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_cfg_start       <= 1'b0;
            o_pipe_flush      <= 1'b0;
            o_stream_en       <= 1'b0;
            o_cfg_fail        <= 1'b0;
            o_gaussian_enable <= 1'b0;
            attempt_cnt       <= '0;
            sof_cnt           <= '0;
            pending           <= 1'b0;
        end else begin
            o_cfg_start  <= (next_state == ST_CFG);
            o_pipe_flush <= (next_state == ST_FLUSH);
            o_stream_en  <= (next_state == ST_RUN);
            o_cfg_fail   <= (next_state == ST_FAIL);

            if (next_state == ST_FAIL) begin
                o_gaussian_enable <= 1'b0;
            end else if ((next_state == ST_FLUSH) && (state != ST_FLUSH)) begin
                o_gaussian_enable <= i_sw_gaussian;
            end

            if ((state == ST_CFG) && (attempt_cnt != ATT_MAX)) begin
                attempt_cnt <= attempt_cnt + 1'b1;
            end else if (((state == ST_WAIT_DONE) && i_cfg_done) ||
                         ((state == ST_RUN) && (next_state == ST_CFG))) begin
                attempt_cnt <= '0;
            end

            if ((next_state == ST_SKIP) && (state != ST_SKIP)) begin
                sof_cnt <= '0;
            end else if ((state == ST_SKIP) && i_sof && (sof_cnt != SOF_MAX)) begin
                sof_cnt <= sof_cnt + 1'b1;
            end

            // Pending tracks the mismatch level, so a toggle-back before sof cancels it.
            if ((state == ST_RUN) && (next_state == ST_RUN)) begin
                pending <= (i_sw_gaussian != o_gaussian_enable);
            end else begin
                pending <= 1'b0;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;

    localparam int SKIP  = 2;
    localparam int FLUSH = 16;
    localparam int CTO   = 100;
    localparam int RETRY = 3;
    localparam int STO   = 1000;

    localparam logic [2:0] S_IDLE = 3'd0, S_CFG = 3'd1, S_WAIT = 3'd2, S_SKIP = 3'd3,
                           S_FLUSH = 3'd4, S_ARM = 3'd5, S_RUN = 3'd6, S_FAIL = 3'd7;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_sof = 1'b0;
    logic       i_cfg_done = 1'b0;
    logic       i_sw_gaussian = 1'b0;
    logic       o_cfg_start;
    logic       o_gaussian_enable;
    logic       o_pipe_flush;
    logic       o_stream_en;
    logic [2:0] o_state;
    logic       o_cfg_fail;

    int   n_asserts = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic exp_gauss = 1'b0;

    frame_scheduler #(
        .SKIP_FRAMES  (SKIP),
        .FLUSH_CYCLES (FLUSH),
        .CFG_TIMEOUT  (CTO),
        .CFG_RETRIES  (RETRY),
        .SOF_TIMEOUT  (STO)
    ) dut (
        .i_clk             (i_clk),
        .i_rstn            (i_rstn),
        .i_sof             (i_sof),
        .i_cfg_done        (i_cfg_done),
        .i_sw_gaussian     (i_sw_gaussian),
        .o_cfg_start       (o_cfg_start),
        .o_gaussian_enable (o_gaussian_enable),
        .o_pipe_flush      (o_pipe_flush),
        .o_stream_en       (o_stream_en),
        .o_state           (o_state),
        .o_cfg_fail        (o_cfg_fail)
    );

    always #4 i_clk = ~i_clk;

    function automatic logic [31:0] obs_vec();
        return {24'd0, o_state, o_cfg_start, o_pipe_flush, o_stream_en, o_cfg_fail, o_gaussian_enable};
    endfunction

    function automatic logic [31:0] exp_vec(input logic [2:0] st, input logic cs, input logic fl,
                                            input logic se, input logic cf, input logic ge);
        return {24'd0, st, cs, fl, se, cf, ge};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_sof();
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
    endtask

    task automatic count_flush(input string tag);
        int n;
        n = 0;
        while (o_pipe_flush === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check(tag, 32'(n), 32'(FLUSH));
        check({tag, "_arm"}, obs_vec(), exp_vec(S_ARM, 0, 0, 0, 0, exp_gauss));
    endtask

    // Starts at a sample where the DUT has just entered CFG; ends in RUN.
    task automatic bring_up(input int done_delay);
        int pulses;
        pulses = 0;
        tick();
        check("wait_entry", obs_vec(), exp_vec(S_WAIT, 0, 0, 0, 0, exp_gauss));
        pulse_sof();
        check("sof_ignored_wait", 32'(o_state), 32'(S_WAIT));
        for (int i = 0; i < done_delay - 2; i++) begin
            tick();
            if (o_cfg_start === 1'b1) pulses++;
        end
        check("single_cfg_start", 32'(pulses), 32'd0);
        i_cfg_done = 1'b1;
        tick();
        check("skip_entry", obs_vec(), exp_vec(S_SKIP, 0, 0, 0, 0, exp_gauss));
        i_cfg_done = 1'b0;
        for (int k = 1; k <= SKIP; k++) begin
            repeat ($urandom_range(1, 20)) tick();
            if (k == SKIP) i_sw_gaussian = 1'($urandom_range(0, 1));
            pulse_sof();
            if (k < SKIP) check("skip_hold", 32'(o_state), 32'(S_SKIP));
        end
        exp_gauss = i_sw_gaussian;
        check("flush_entry", obs_vec(), exp_vec(S_FLUSH, 0, 1, 0, 0, exp_gauss));
        count_flush("flush_len");
        repeat ($urandom_range(1, 30)) tick();
        check("arm_no_stream", 32'(o_stream_en), 32'd0);
        pulse_sof();
        check("run_entry", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));
    endtask

    initial begin
        int n;
        int t0;
        int q[$];

        // Reset state
        #1;
        check("reset_async", obs_vec(), exp_vec(S_IDLE, 0, 0, 0, 0, 0));
        repeat (3) tick();
        check("reset_hold", obs_vec(), exp_vec(S_IDLE, 0, 0, 0, 0, 0));

        // Normal bring-up with done 50 clocks after cfg_start
        i_rstn = 1'b1;
        tick();
        check("first_cfg", obs_vec(), exp_vec(S_CFG, 1, 0, 0, 0, 0));
        bring_up(50);

        // Steady RUN under random sof spacing
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(1, STO / 4)) tick();
            pulse_sof();
            check("run_steady", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));
        end

        // Switch glitch between two sofs
        repeat ($urandom_range(2, 10)) tick();
        i_sw_gaussian = ~exp_gauss;
        repeat ($urandom_range(1, 5)) tick();
        i_sw_gaussian = exp_gauss;
        repeat ($urandom_range(3, 10)) tick();
        pulse_sof();
        check("glitch_sof", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));
        repeat (5) tick();
        check("glitch_after", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));

        // Mode change in RUN
        i_sw_gaussian = ~exp_gauss;
        repeat ($urandom_range(2, 20)) tick();
        check("pending_still_run", 32'(o_stream_en), 32'd1);
        pulse_sof();
        exp_gauss = i_sw_gaussian;
        check("mode_flush", obs_vec(), exp_vec(S_FLUSH, 0, 1, 0, 0, exp_gauss));
        count_flush("mode_flush_len");
        repeat ($urandom_range(1, 30)) tick();
        pulse_sof();
        check("mode_run", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));

        // Sof coincident with the watchdog keeps RUN
        repeat (STO - 1) tick();
        check("wd_edge_run", 32'(o_state), 32'(S_RUN));
        pulse_sof();
        check("wd_coincident", obs_vec(), exp_vec(S_RUN, 0, 0, 1, 0, exp_gauss));

        // Lost camera: watchdog returns to CFG
        n = 0;
        while (o_state !== S_CFG && n < STO + 100) begin
            tick();
            n++;
        end
        check("wd_latency", 32'(n), 32'(STO));
        check("wd_cfg", obs_vec(), exp_vec(S_CFG, 1, 0, 0, 0, exp_gauss));
        bring_up($urandom_range(3, CTO - 10));

        // Reset in the middle of a flush
        i_sw_gaussian = ~exp_gauss;
        repeat (3) tick();
        pulse_sof();
        exp_gauss = i_sw_gaussian;
        check("pre_reset_flush", obs_vec(), exp_vec(S_FLUSH, 0, 1, 0, 0, exp_gauss));
        repeat (7) tick();
        check("flush_clock8", 32'(o_pipe_flush), 32'd1);
        i_rstn = 1'b0;
        #1;
        exp_gauss = 1'b0;
        check("reset_mid_flush", obs_vec(), exp_vec(S_IDLE, 0, 0, 0, 0, 0));
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
        check("restart_cfg", obs_vec(), exp_vec(S_CFG, 1, 0, 0, 0, 0));
        bring_up($urandom_range(3, CTO - 10));

        // Retries exhausted without done
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        tick();
        check("retry_first_cfg", obs_vec(), exp_vec(S_CFG, 1, 0, 0, 0, 0));
        t0 = cyc;
        q.push_back(cyc);
        n = 0;
        while (o_state !== S_FAIL && n < RETRY * (CTO + 1) + 50) begin
            if (n == 10) i_sof = 1'b1;
            tick();
            i_sof = 1'b0;
            n++;
            if (o_cfg_start === 1'b1) q.push_back(cyc);
        end
        check("retry_pulses", 32'(q.size()), 32'(RETRY));
        for (int i = 0; i < q.size() && i < RETRY; i++) begin
            check("retry_spacing", 32'(q[i] - t0), 32'(i * (CTO + 1)));
        end
        check("fail_time", 32'(cyc - t0), 32'(RETRY * (CTO + 1)));
        check("fail_outputs", obs_vec(), exp_vec(S_FAIL, 0, 0, 0, 1, 0));
        i_cfg_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_sw_gaussian = ~i_sw_gaussian;
            repeat (3) tick();
            pulse_sof();
        end
        check("fail_terminal", obs_vec(), exp_vec(S_FAIL, 0, 0, 0, 1, 0));
        i_rstn = 1'b0;
        #1;
        check("fail_reset_exit", obs_vec(), exp_vec(S_IDLE, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
